// File: rtl/pe_act_sched.sv
// PE activation scheduler: pops the activation queue and issues OUT_NUM MAC commands per activation.
// Defining PE_ZERO_SKIP_EN makes zero-valued activations issue no MACs; they are counted in skip_cnt instead.
//
// state | meaning
// IDLE  | waiting for an activation; pops when enabled and the queue is non-empty
// ISSUE | issuing MAC commands for act_reg, cnt selects the output accumulator
// DRAIN | end-of-layer marker popped, waiting for in-flight MACs to retire
// DONE  | one-cycle layer_done pulse
module pe_act_sched #(
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 10,
    parameter int OUT_NUM  = 4,
    parameter int W_ADDR_W = 12,
    parameter int INFL_W   = 4,
    localparam int SEL_W   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sched_en,
    input  logic                    queue_empty,
    input  logic [IDX_W+DATA_W-1:0] act_head,
    output logic                    pop_act,
    output logic                    mac_valid,
    input  logic                    mac_ready,
    output logic [DATA_W-1:0]       mac_act,
    output logic [W_ADDR_W-1:0]     mac_waddr,
    output logic [SEL_W-1:0]        mac_out_sel,
    input  logic                    mac_retire,
    output logic                    busy,
    output logic                    layer_done,
    output logic                    err_underflow,
    output logic [15:0]             skip_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [SEL_W-1:0]  CNT_LAST = SEL_W'(OUT_NUM - 1);
    localparam logic [INFL_W-1:0] INFL_MAX = '1;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  cnt, cnt_nxt;
    logic [INFL_W-1:0] infl;
    logic [IDX_W-1:0]  act_idx;
    logic [DATA_W-1:0] act_val;
    logic [IDX_W-1:0]  head_idx;
    logic [DATA_W-1:0] head_val;
    logic              head_marker;
    logic              head_skip;
    logic              can_load;
    logic              hs;

    assign head_idx    = act_head[IDX_W+DATA_W-1:DATA_W];
    assign head_val    = act_head[DATA_W-1:0];
    assign head_marker = &head_idx;
`ifdef PE_ZERO_SKIP_EN
    assign head_skip   = !head_marker && (head_val == '0);
`else
    assign head_skip   = 1'b0;
`endif

    // Gated by rst so the queue is never popped while the state registers are held in reset.
    assign can_load    = sched_en && !queue_empty && !rst;
    assign hs          = mac_valid && mac_ready;

    assign mac_act     = act_val;
    assign mac_out_sel = cnt;
    assign mac_waddr   = W_ADDR_W'(act_idx) * W_ADDR_W'(OUT_NUM) + W_ADDR_W'(cnt);
    assign busy        = (state != IDLE) || (infl != '0);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pop_act    = 1'b0;
        mac_valid  = 1'b0;
        layer_done = 1'b0;
        case (state)
            IDLE: begin
                if (can_load) pop_act = 1'b1;
            end
            ISSUE: begin
                mac_valid = (infl != INFL_MAX);
                if (mac_valid && mac_ready) begin
                    if (cnt != CNT_LAST) cnt_nxt = cnt + 1'b1;
                    else if (can_load)   pop_act = 1'b1;
                    else                 state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (infl == '0) state_nxt = DONE;
            end
            DONE: begin
                layer_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A load from IDLE or at the last handshake picks the next state from the popped head.
        if (pop_act) begin
            cnt_nxt = '0;
            if (head_marker)    state_nxt = DRAIN;
            else if (head_skip) state_nxt = IDLE;
            else                state_nxt = ISSUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            act_idx <= '0;
            act_val <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pop_act) begin
                act_idx <= head_idx;
                act_val <= head_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl          <= '0;
            err_underflow <= 1'b0;
        end else begin
            case ({hs, mac_retire})
                2'b10: infl <= infl + 1'b1;
                2'b01: begin
                    if (infl != '0) infl <= infl - 1'b1;
                    else            err_underflow <= 1'b1;
                end
                default: infl <= infl;
            endcase
        end
    end

`ifdef PE_ZERO_SKIP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         skip_cnt <= '0;
        else if (pop_act && head_skip && skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
    end
`else
    assign skip_cnt = '0;
`endif

endmodule
